// File: rtl/conv_window_addr_gen.sv
// Sliding-window address generator for the convolution datapath.
// Issues one window (WIN_W*WIN_H read addresses) per handshake, walking the
// window anchor in raster order with a fixed stride, channel by channel.
// The anchor is kept incrementally (column, row and channel bases), so the
// only output-side arithmetic is a per-lane constant add.

module conv_lane_addr #(
  parameter int ADDR_W = 16,
  parameter int OFFSET = 0
) (
  input  logic [ADDR_W-1:0] anchor,
  input  logic              en,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [ADDR_W-1:0] OFF = ADDR_W'(OFFSET);

  // Lane address: anchor plus the lane's fixed offset, forced to 0 when idle.
  assign addr = en ? anchor + OFF : '0;
endmodule

module conv_window_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int IMG_W     = 30,
  parameter int IMG_H     = 30,
  parameter int WIN_W     = 5,
  parameter int WIN_H     = 5,
  parameter int STRIDE    = 1,
  parameter int CH_NUM    = 1,
  parameter int CH_STRIDE = IMG_W*IMG_H
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIN_W*WIN_H*ADDR_W-1:0] addr_out,
  output logic [15:0]                   win_x,
  output logic [15:0]                   win_y,
  output logic [15:0]                   ch_idx,
  output logic                          last,
  output logic                          busy,
  output logic                          done
);
  localparam int NUM_LANES = WIN_W*WIN_H;
  localparam int X_MAX     = IMG_W - WIN_W;
  localparam int Y_MAX     = IMG_H - WIN_H;

  localparam logic [ADDR_W-1:0] X_STEP   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE*IMG_W);
  localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(CH_STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]       x_q, y_q, ch_q;
  logic [ADDR_W-1:0] anchor_q;    // current window pixel (0,0)
  logic [ADDR_W-1:0] row_base_q;  // base + ch*CH_STRIDE + y*IMG_W
  logic [ADDR_W-1:0] ch_base_q;   // base + ch*CH_STRIDE

  logic [16:0] x_nxt, y_nxt;
  logic        col_ok, row_ok, ch_last, last_win, fire;

  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr;

  // Step legality from registered counters only.
  always_comb begin
    x_nxt    = {1'b0, x_q} + 17'(STRIDE);
    y_nxt    = {1'b0, y_q} + 17'(STRIDE);
    col_ok   = (x_nxt <= 17'(X_MAX));
    row_ok   = (y_nxt <= 17'(Y_MAX));
    ch_last  = (ch_q == 16'(CH_NUM-1));
    last_win = !col_ok && !row_ok && ch_last;
    fire     = (state == S_RUN) && out_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && last_win) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window counters and incrementally maintained anchor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      ch_q       <= '0;
      anchor_q   <= '0;
      row_base_q <= '0;
      ch_base_q  <= '0;
    end else if (state == S_IDLE && start) begin
      x_q        <= '0;
      y_q        <= '0;
      ch_q       <= '0;
      anchor_q   <= base_addr;
      row_base_q <= base_addr;
      ch_base_q  <= base_addr;
    end else if (fire && !last_win) begin
      if (col_ok) begin
        x_q      <= x_nxt[15:0];
        anchor_q <= anchor_q + X_STEP;
      end else if (row_ok) begin
        x_q        <= '0;
        y_q        <= y_nxt[15:0];
        anchor_q   <= row_base_q + ROW_STEP;
        row_base_q <= row_base_q + ROW_STEP;
      end else begin
        x_q        <= '0;
        y_q        <= '0;
        ch_q       <= ch_q + 16'd1;
        anchor_q   <= ch_base_q + CH_STEP;
        row_base_q <= ch_base_q + CH_STEP;
        ch_base_q  <= ch_base_q + CH_STEP;
      end
    end
  end

  // One adder per lane: lane k = r*WIN_W+c sits at anchor + r*IMG_W + c.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    conv_lane_addr #(
      .ADDR_W(ADDR_W),
      .OFFSET((k / WIN_W) * IMG_W + (k % WIN_W))
    ) u_lane (
      .anchor(anchor_q),
      .en    (state == S_RUN),
      .addr  (lane_addr[k])
    );
  end

  assign addr_out = lane_addr;
  assign win_x    = x_q;
  assign win_y    = y_q;
  assign ch_idx   = ch_q;
  assign last     = (state == S_RUN) && last_win;
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench: a raster-order window model fills per-DUT queues; negedge
// monitors compare every presented window and track the done pulse.
module tb_conv_window_addr_gen;
  typedef struct {
    int     x;
    int     y;
    int     ch;
    longint anchor;
    bit     last;
  } exp_t;

  // DUT A: default geometry. DUT B: small strided, two channels, 10-bit wrap.
  localparam int B_AW = 10, B_IW = 8, B_IH = 8, B_WW = 3, B_WH = 3, B_S = 2, B_CH = 2;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic         start_a = 0, ready_a = 1, valid_a, last_a, busy_a, done_a;
  logic [15:0]  base_a = 0, x_a, y_a, ch_a;
  logic [399:0] addr_a;

  logic         start_b = 0, ready_b = 1, valid_b, last_b, busy_b, done_b;
  logic [9:0]   base_b = 0;
  logic [15:0]  x_b, y_b, ch_b;
  logic [89:0]  addr_b;

  conv_window_addr_gen dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a),
    .out_valid(valid_a), .out_ready(ready_a), .addr_out(addr_a),
    .win_x(x_a), .win_y(y_a), .ch_idx(ch_a), .last(last_a),
    .busy(busy_a), .done(done_a));

  conv_window_addr_gen #(
    .ADDR_W(B_AW), .IMG_W(B_IW), .IMG_H(B_IH), .WIN_W(B_WW), .WIN_H(B_WH),
    .STRIDE(B_S), .CH_NUM(B_CH)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b),
    .out_valid(valid_b), .out_ready(ready_b), .addr_out(addr_b),
    .win_x(x_b), .win_y(y_b), .ch_idx(ch_b), .last(last_b),
    .busy(busy_b), .done(done_b));

  int   checks = 0, errors = 0;
  exp_t q_a[$], q_b[$];
  int   pend_a = 0, pend_b = 0, dcnt_a = 0, dcnt_b = 0;
  bit   rnd_a = 0, rnd_b = 0;

  // Reference: every window of a run, in raster order, channel by channel.
  task automatic model(input int which, input int iw, ih, ww, wh, s, chn, chs,
                       input longint base);
    int ow, oh;
    exp_t e;
    ow = (iw - ww) / s + 1;
    oh = (ih - wh) / s + 1;
    for (int c = 0; c < chn; c++)
      for (int j = 0; j < oh; j++)
        for (int i = 0; i < ow; i++) begin
          e.x = i * s; e.y = j * s; e.ch = c;
          e.anchor = base + longint'(c * chs + e.y * iw + e.x);
          e.last = (c == chn - 1) && (j == oh - 1) && (i == ow - 1);
          if (which == 0) q_a.push_back(e); else q_b.push_back(e);
        end
  endtask

  task automatic cmp(input string nm, input logic [1023:0] ga, input logic [15:0] gx, gy, gc,
                     input logic gl, input exp_t e, input int iw, ww, nl, aw);
    int bad;
    longint ev, gv, evb, gvb;
    bad = -1; evb = 0; gvb = 0;
    for (int k = 0; k < nl; k++) begin
      ev = (e.anchor + longint'((k / ww) * iw + (k % ww))) % (longint'(1) << aw);
      gv = longint'((ga >> (k * aw)) & ((1024'(1) << aw) - 1));
      if (bad < 0 && gv != ev) begin bad = k; evb = ev; gvb = gv; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s addr lane %0d at x=%0d y=%0d ch=%0d: got %0d exp %0d",
               nm, bad, e.x, e.y, e.ch, gvb, evb);
    end
    checks++;
    if (gx !== 16'(e.x) || gy !== 16'(e.y) || gc !== 16'(e.ch) || gl !== e.last) begin
      errors++;
      $display("FAIL %s pos: got x=%0d y=%0d ch=%0d last=%0b exp x=%0d y=%0d ch=%0d last=%0b",
               nm, gx, gy, gc, gl, e.x, e.y, e.ch, e.last);
    end
  endtask

  // Monitor A: windows, hold under backpressure, done pulse timing.
  always @(negedge clk) begin
    if (!rst_n) pend_a = 0;
    else begin
      if (done_a === 1'b1) dcnt_a++;
      if (pend_a == 1) begin
        checks++;
        if (!(done_a === 1'b1 && valid_a === 1'b0 && busy_a === 1'b1)) begin
          errors++;
          $display("FAIL A done_cycle: got done=%0b valid=%0b busy=%0b exp 1 0 1", done_a, valid_a, busy_a);
        end
        pend_a = 2;
      end else if (pend_a == 2) begin
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
          errors++;
          $display("FAIL A after_done: got busy=%0b done=%0b exp 0 0", busy_a, done_a);
        end
        pend_a = 0;
      end
      if (valid_a === 1'b1) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL A unexpected window x=%0d y=%0d ch=%0d exp none", x_a, y_a, ch_a);
        end else begin
          cmp("A", 1024'(addr_a), x_a, y_a, ch_a, last_a, q_a[0], 30, 5, 25, 16);
          if (ready_a) begin
            if (q_a[0].last) pend_a = 1;
            void'(q_a.pop_front());
          end
        end
      end
    end
  end

  // Monitor B: same checks for the small configuration.
  always @(negedge clk) begin
    if (!rst_n) pend_b = 0;
    else begin
      if (done_b === 1'b1) dcnt_b++;
      if (pend_b == 1) begin
        checks++;
        if (!(done_b === 1'b1 && valid_b === 1'b0 && busy_b === 1'b1)) begin
          errors++;
          $display("FAIL B done_cycle: got done=%0b valid=%0b busy=%0b exp 1 0 1", done_b, valid_b, busy_b);
        end
        pend_b = 2;
      end else if (pend_b == 2) begin
        checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
          errors++;
          $display("FAIL B after_done: got busy=%0b done=%0b exp 0 0", busy_b, done_b);
        end
        pend_b = 0;
      end
      if (valid_b === 1'b1) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL B unexpected window x=%0d y=%0d ch=%0d exp none", x_b, y_b, ch_b);
        end else begin
          cmp("B", 1024'(addr_b), x_b, y_b, ch_b, last_b, q_b[0], B_IW, B_WW, B_WW*B_WH, B_AW);
          if (ready_b) begin
            if (q_b[0].last) pend_b = 1;
            void'(q_b.pop_front());
          end
        end
      end
    end
  end

  // Consumer readiness: always ready or randomly stalling.
  initial forever begin
    @(posedge clk); #1;
    ready_a = rnd_a ? ($urandom_range(3) != 0) : 1'b1;
    ready_b = rnd_b ? ($urandom_range(2) != 0) : 1'b1;
  end

  task automatic check_idle_a(input string nm);
    checks++;
    if (valid_a !== 0 || busy_a !== 0 || done_a !== 0 || last_a !== 0 || addr_a !== '0 ||
        x_a !== 0 || y_a !== 0 || ch_a !== 0) begin
      errors++;
      $display("FAIL %s: got valid=%0b busy=%0b done=%0b last=%0b x=%0d y=%0d ch=%0d lane0=%0d exp all 0",
               nm, valid_a, busy_a, done_a, last_a, x_a, y_a, ch_a, addr_a[15:0]);
    end
  endtask

  // Run on A; poke pulses start mid-run and in the DONE cycle (both ignored).
  task automatic run_a(input logic [15:0] base, input bit rnd, input bit poke);
    int d0;
    bit fin;
    d0 = dcnt_a; fin = 0;
    model(0, 30, 30, 5, 5, 1, 1, 900, longint'(base));
    rnd_a = rnd; base_a = base; start_a = 1;
    @(posedge clk); #1 start_a = 0; base_a = 16'($urandom);
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b1) begin errors++; $display("FAIL A latency: got valid=%0b exp 1", valid_a); end
    @(posedge clk); #1;
    for (int n = 0; n < 5000; n++) begin
      start_a = poke && ((n == 10 && busy_a && !done_a && q_a.size() > 3) || done_a);
      if (start_a) base_a = 16'($urandom);
      if (q_a.size() == 0 && !busy_a && pend_a == 0) begin fin = 1; break; end
      @(posedge clk); #1;
    end
    start_a = 0;
    checks++;
    if (!fin || dcnt_a != d0 + 1) begin
      errors++;
      $display("FAIL A run_end: got finished=%0b done_pulses=%0d left=%0d exp 1 1 0", fin, dcnt_a - d0, q_a.size());
    end
  endtask

  task automatic run_b(input logic [9:0] base, input bit rnd, input bit poke);
    int d0;
    bit fin;
    d0 = dcnt_b; fin = 0;
    model(1, B_IW, B_IH, B_WW, B_WH, B_S, B_CH, B_IW*B_IH, longint'(base));
    rnd_b = rnd; base_b = base; start_b = 1;
    @(posedge clk); #1 start_b = 0; base_b = 10'($urandom);
    for (int n = 0; n < 500; n++) begin
      start_b = poke && ((n == 3 && busy_b && !done_b && q_b.size() > 3) || done_b);
      if (start_b) base_b = 10'($urandom);
      if (q_b.size() == 0 && !busy_b && pend_b == 0) begin fin = 1; break; end
      @(posedge clk); #1;
    end
    start_b = 0;
    checks++;
    if (!fin || dcnt_b != d0 + 1) begin
      errors++;
      $display("FAIL B run_end: got finished=%0b done_pulses=%0d left=%0d exp 1 1 0", fin, dcnt_b - d0, q_b.size());
    end
  endtask

  initial begin
    int d0;
    @(negedge clk);
    check_idle_a("A reset");
    checks++;
    if (valid_b !== 0 || busy_b !== 0 || done_b !== 0 || addr_b !== '0) begin
      errors++;
      $display("FAIL B reset: got valid=%0b busy=%0b done=%0b exp 0", valid_b, busy_b, done_b);
    end
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    run_a(16'd0, 1'b0, 1'b1);
    run_a(16'd40000, 1'b1, 1'b0);
    run_b(10'd0, 1'b0, 1'b1);
    run_b(10'd1000, 1'b1, 1'b1);
    run_b(10'($urandom), 1'b1, 1'b0);

    // Reset in the middle of a run: outputs clear, no done, clean restart.
    model(0, 30, 30, 5, 5, 1, 1, 900, 64'd300);
    rnd_a = 1; base_a = 16'd300; start_a = 1;
    @(posedge clk); #1 start_a = 0;
    repeat (150) @(posedge clk);
    #1 rst_n = 0;
    d0 = dcnt_a;
    @(negedge clk);
    check_idle_a("A mid_reset");
    q_a.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    checks++;
    if (dcnt_a != d0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL A no_done_after_reset: got pulses=%0d busy=%0b exp 0 0", dcnt_a - d0, busy_a);
    end
    #1;
    run_a(16'd7, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
